if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- instruction-fetch stage.
// Owns the PC and a direct-mapped, one-word-per-line instruction cache.
// Misses are refilled from instruction memory over a req/ack handshake.
// Outputs npc/instr/hit feed the IF/ID register, which captures only on hit.
// Optional build macro: FETCH_PERF_EN adds hit_cnt/miss_cnt counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IDX_BITS  = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] npc,
  output logic [31:0] instr,
  output logic        hit
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  typedef enum logic {RUN = 1'b0, REFILL = 1'b1} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [31:0]           pc_reg;
  logic [31:0]           pc_next;
  logic                  mem_req_reg;
  logic [31:0]           mem_addr_reg;
  logic                  redirect_pending_reg;
  logic [31:0]           saved_target_reg;

  logic [LINES-1:0]      valid_reg;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  lookup_hit;
  logic                  start_refill;
  logic                  fill_en;

  assign idx        = pc_reg[IDX_BITS+1:2];
  assign pc_tag     = pc_reg[31:IDX_BITS+2];
  assign lookup_hit = valid_reg[idx] && (tag_mem[idx] == pc_tag);

  // A refill only starts on a clean miss: no redirect and no stall this cycle.
  assign start_refill = (state_reg == RUN) && !br_taken && !stall && !lookup_hit;
  // The PC holds during REFILL, so idx/pc_tag still address the missed line.
  assign fill_en      = (state_reg == REFILL) && mem_ack;

  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: RUN -> REFILL on a clean miss, back on mem_ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (start_refill) state_next = REFILL;
      REFILL:  if (mem_ack)      state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic: a fetch is valid only when the PC is about to advance sequentially.
  always_comb begin
    hit   = (state_reg == RUN) && lookup_hit && !stall && !br_taken;
    instr = hit ? data_mem[idx] : NOP_INSTR;
    npc   = pc_reg + 32'd4;
  end

  // Next PC: redirect beats stall beats sequential advance; a miss holds.
  always_comb begin
    pc_next = pc_reg;
    case (state_reg)
      RUN: begin
        if (br_taken)                 pc_next = br_target;
        else if (!stall && lookup_hit) pc_next = pc_reg + 32'd4;
      end
      REFILL: begin
        // A redirect arriving with the ack is newer than any saved one.
        if (mem_ack) begin
          if (br_taken)                  pc_next = br_target;
          else if (redirect_pending_reg) pc_next = saved_target_reg;
        end
      end
      default: pc_next = pc_reg;
    endcase
  end

  // PC, refill request and deferred-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg               <= RESET_PC;
      mem_req_reg          <= 1'b0;
      mem_addr_reg         <= 32'h0;
      redirect_pending_reg <= 1'b0;
      saved_target_reg     <= 32'h0;
    end else begin
      pc_reg <= pc_next;
      if (start_refill) begin
        mem_req_reg  <= 1'b1;
        mem_addr_reg <= {pc_reg[31:2], 2'b00};
      end else if (fill_en) begin
        mem_req_reg  <= 1'b0;
      end
      if (state_reg == REFILL) begin
        if (mem_ack) begin
          redirect_pending_reg <= 1'b0;
        end else if (br_taken) begin
          redirect_pending_reg <= 1'b1;
          saved_target_reg     <= br_target;
        end
      end
    end
  end

  // Cache data and tag arrays; contents are qualified by valid_reg, so no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= pc_tag;
    end
  end

  // Per-line valid bits: cleared on reset, set when their line is refilled.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_en && (idx == IDX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

`ifdef FETCH_PERF_EN
  // Performance counters: delivered fetches and refills started; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (hit)          hit_cnt  <= hit_cnt + 32'd1;
      if (start_refill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit (default parameters).
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] npc;
  logic [31:0] instr;
  logic        hit;
`ifdef FETCH_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  if_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .npc       (npc),
    .instr     (instr),
    .hit       (hit)
`ifdef FETCH_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the current cycle (just after a rising edge) and let them settle.
  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] d);
    stall     = s;
    br_taken  = b;
    br_target = t;
    mem_ack   = a;
    mem_rdata = d;
    #1;
    $display("t=%0t stall=%b br=%b tgt=%h ack=%b rdata=%h -> req=%b addr=%h hit=%b instr=%h npc=%h",
             $time, s, b, t, a, d, mem_req, mem_addr, hit, instr, npc);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state, cold miss at pc=0
    idle();
    chk("rst_hit", {31'h0, hit}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    cyc();
    // Refill request for 0, ack at the earliest cycle
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    chk("cold_req", {31'h0, mem_req}, 32'h1);
    chk("cold_addr", mem_addr, 32'h0);
    chk("cold_hit", {31'h0, hit}, 32'h0);
    cyc();
    idle();
    chk("cold_fill_hit", {31'h0, hit}, 32'h1);
    chk("cold_fill_instr", instr, 32'h1111_1111);
    chk("cold_fill_npc", npc, 32'h4);
    chk("cold_req_drop", {31'h0, mem_req}, 32'h0);
    cyc();
    // pc=4 misses, fill it
    idle();
    chk("pc4_miss", {31'h0, hit}, 32'h0);
    chk("pc4_npc", npc, 32'h8);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    chk("pc4_addr", mem_addr, 32'h4);
    cyc();
    idle();
    chk("pc4_hit", {31'h0, hit}, 32'h1);
    chk("pc4_instr", instr, 32'h2222_2222);
    cyc();
    // pc=8 misses, fill it
    idle();
    chk("pc8_miss", {31'h0, hit}, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    chk("pc8_addr", mem_addr, 32'h8);
    cyc();
    // Redirect to 0 on a hit cycle suppresses hit
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("br_hit", {31'h0, hit}, 32'h0);
    chk("br_instr", instr, 32'h0);
    chk("br_npc", npc, 32'hC);
    cyc();
    // Warm loop: three hits, no requests
    idle();
    chk("warm0_hit", {31'h0, hit}, 32'h1);
    chk("warm0_npc", npc, 32'h4);
    chk("warm0_instr", instr, 32'h1111_1111);
    chk("warm0_req", {31'h0, mem_req}, 32'h0);
    cyc();
    idle();
    chk("warm1_hit", {31'h0, hit}, 32'h1);
    chk("warm1_npc", npc, 32'h8);
    cyc();
    idle();
    chk("warm2_hit", {31'h0, hit}, 32'h1);
    chk("warm2_npc", npc, 32'hC);
    chk("warm2_instr", instr, 32'h3333_3333);
    cyc();
    // pc=12 is a miss, but a redirect to 8 prevents any refill
    drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
    chk("br_miss_hit", {31'h0, hit}, 32'h0);
    cyc();
    // Stall three cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_hit", {31'h0, hit}, 32'h0);
      chk("stall_npc", npc, 32'hC);
      chk("stall_req", {31'h0, mem_req}, 32'h0);
      cyc();
    end
    idle();
    chk("unstall_hit", {31'h0, hit}, 32'h1);
    chk("unstall_npc", npc, 32'hC);
    chk("unstall_instr", instr, 32'h3333_3333);
    cyc();
    // pc=12: redirect to 0x40
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("br40_npc", npc, 32'h10);
    cyc();
    // 0x40 conflicts with line 0 -> miss
    idle();
    chk("c40_hit", {31'h0, hit}, 32'h0);
    chk("c40_npc", npc, 32'h44);
    chk("c40_req", {31'h0, mem_req}, 32'h0);
    cyc();
    // Redirect to 0x100 while refilling 0x40
    drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("rf_req", {31'h0, mem_req}, 32'h1);
    chk("rf_addr", mem_addr, 32'h40);
    chk("rf_hit", {31'h0, hit}, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
    chk("rf_req_hold", {31'h0, mem_req}, 32'h1);
    chk("rf_addr_hold", mem_addr, 32'h40);
    cyc();
    // Saved target applied at ack; 0x100 maps to line 0 with another tag
    idle();
    chk("pend_npc", npc, 32'h104);
    chk("pend_hit", {31'h0, hit}, 32'h0);
    chk("pend_req", {31'h0, mem_req}, 32'h0);
    cyc();
    // Ack and redirect together: the new target wins
    drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h5555_5555);
    chk("r100_req", {31'h0, mem_req}, 32'h1);
    chk("r100_addr", mem_addr, 32'h100);
    cyc();
    // 0x40 was evicted by 0x100
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("evict40_npc", npc, 32'h44);
    cyc();
    idle();
    chk("evict0_hit", {31'h0, hit}, 32'h0);
    chk("evict0_npc", npc, 32'h4);
    cyc();
    idle();
    chk("evict0_req", {31'h0, mem_req}, 32'h1);
    chk("evict0_addr", mem_addr, 32'h0);
    // Reset while the refill is outstanding
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    // Stray ack in RUN is ignored; redirect to 4 (line 1 was valid before reset)
    drive(1'b0, 1'b1, 32'h4, 1'b1, 32'h9999_9999);
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_npc", npc, 32'h4);
    chk("mid_rst_hit", {31'h0, hit}, 32'h0);
    cyc();
    idle();
    chk("inval4_hit", {31'h0, hit}, 32'h0);
    chk("inval4_npc", npc, 32'h8);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    chk("refill4_req", {31'h0, mem_req}, 32'h1);
    chk("refill4_addr", mem_addr, 32'h4);
    cyc();
    idle();
    chk("refill4_hit", {31'h0, hit}, 32'h1);
    chk("refill4_instr", instr, 32'h1234_5678);
    chk("refill4_npc", npc, 32'h8);
    // Redirect to the top word: npc wraps to 0
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("wrapbr_hit", {31'h0, hit}, 32'h0);
    cyc();
    idle();
    chk("wrap_npc", npc, 32'h0);
    chk("wrap_hit", {31'h0, hit}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
